// File: rtl/reg_pipe_pkg.sv
// ---------------------------------------------------------------------------
// reg_pipe_pkg
// Shared definitions for the reg_pipe register pipeline.
//   REG_PIPE_DEF_WIDTH : default data width in bits
//   REG_PIPE_DEF_DEPTH : default number of register stages
//   occ_width()        : bit width needed to hold a count of 0..depth
// ---------------------------------------------------------------------------
package reg_pipe_pkg;

  localparam int REG_PIPE_DEF_WIDTH = 8;
  localparam int REG_PIPE_DEF_DEPTH = 4;

  // The occupancy counter must represent every value from 0 to depth
  // inclusive, so it needs room for depth+1 distinct values.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// ---------------------------------------------------------------------------
// reg_pipe_stage
// One stage of the reg_pipe: a WIDTH-bit data register plus a valid flop.
// Optional synchronous flush is compiled in when REG_PIPE_SCLR_EN is defined.
//
// Ports
//   clk     : clock, rising-edge active
//   rst_n   : asynchronous active-low reset (data=RESET_VAL, valid=0)
//   en      : advance enable; 0 holds data and valid
//   sclr    : synchronous flush (only with REG_PIPE_SCLR_EN)
//   d_in    : data from the previous stage (or the pipe input)
//   v_in    : valid flag from the previous stage (or the pipe input)
//   d_out   : registered data
//   v_out   : registered valid flag
// ---------------------------------------------------------------------------
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int                 WIDTH     = REG_PIPE_DEF_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef REG_PIPE_SCLR_EN
  input  logic             sclr,
`endif
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);

  // The valid flag always follows its source when advancing, but the data
  // register only captures when the source is valid. A bubble therefore
  // leaves the previous word in place instead of loading garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out <= RESET_VAL;
      v_out <= 1'b0;
    end
`ifdef REG_PIPE_SCLR_EN
    else if (sclr) begin
      d_out <= RESET_VAL;
      v_out <= 1'b0;
    end
`endif
    else if (en) begin
      v_out <= v_in;
      if (v_in) begin
        d_out <= d_in;
      end
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// ---------------------------------------------------------------------------
// reg_pipe
// Parametrised register pipeline carrying a WIDTH-bit word plus a valid flag
// through DEPTH stages, with a per-cycle advance enable and a live count of
// valid words in flight. Generic delay/retiming element between datapath
// blocks.
//
// Build option
//   REG_PIPE_SCLR_EN : when defined, adds the sclr port and synchronous flush.
//
// Parameters
//   WIDTH     : data width in bits (>=1)
//   DEPTH     : number of register stages (>=1)
//   RESET_VAL : value loaded into every data stage on reset/flush
//
// Ports
//   clk     : clock, rising-edge active
//   rst_n   : asynchronous active-low reset
//   en      : advance enable; 0 = whole pipe (and occ) holds
//   sclr    : synchronous flush (only with REG_PIPE_SCLR_EN)
//   d       : input data word
//   d_valid : d carries a valid word
//   q       : data of the last stage
//   q_valid : valid flag of the last stage
//   occ     : number of stages currently holding a valid word
// ---------------------------------------------------------------------------
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int                 WIDTH     = REG_PIPE_DEF_WIDTH,
  parameter int                 DEPTH     = REG_PIPE_DEF_DEPTH,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
`ifdef REG_PIPE_SCLR_EN
  input  logic                         sclr,
`endif
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [occ_width(DEPTH)-1:0]  occ
);

  localparam int               OCC_W   = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  // Index 0 is the pipe input; index i+1 is the output of stage i.
  logic [WIDTH-1:0] data_s [DEPTH+1];
  logic [DEPTH:0]   valid_s;

  assign data_s[0]  = d;
  assign valid_s[0] = d_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : gen_stage
    reg_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
`ifdef REG_PIPE_SCLR_EN
      .sclr  (sclr),
`endif
      .d_in  (data_s[i]),
      .v_in  (valid_s[i]),
      .d_out (data_s[i+1]),
      .v_out (valid_s[i+1])
    );
  end

  // The last stage drives the outputs directly.
  assign q       = data_s[DEPTH];
  assign q_valid = valid_s[DEPTH];

  // Occupancy is tracked incrementally: a word entering adds one, a word
  // leaving (the registered q_valid shifting out) subtracts one. Entry and
  // exit on the same edge cancel. When the pipe is full, q_valid is
  // necessarily 1, so the count can never exceed DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end
`ifdef REG_PIPE_SCLR_EN
    else if (sclr) begin
      occ <= '0;
    end
`endif
    else if (en) begin
      case ({d_valid, q_valid})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_pipe.sv
// ---------------------------------------------------------------------------
// tb_reg_pipe
// Directed, table-driven bench for reg_pipe (WIDTH=8, DEPTH=4, RESET_VAL=0).
// Each table row is applied for one clock edge and the outputs are compared
// on the following falling edge. Reset, mid-stream reset and flush are
// hand-written sequences. Flush checks are compiled with REG_PIPE_SCLR_EN.
// ---------------------------------------------------------------------------
module tb_reg_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
`ifdef REG_PIPE_SCLR_EN
  logic             sclr;
`endif
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [OCC_W-1:0] occ;

  int vectors     = 0;
  int miscompares = 0;
  bit invOn       = 1'b0;

  typedef struct {
    string            name;
    logic             en;
    logic             dv;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] expQ;
    logic             expQv;
    logic [OCC_W-1:0] expOcc;
  } vec_t;

  vec_t tbl[$];

  reg_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (8'h00)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
`ifdef REG_PIPE_SCLR_EN
    .sclr    (sclr),
`endif
    .d       (d),
    .d_valid (d_valid),
    .q       (q),
    .q_valid (q_valid),
    .occ     (occ)
  );

  // Free-running 10 ns clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Occupancy must always equal the number of valid flags in the stages.
  always @(negedge clk) begin
    if (invOn) begin
      vectors++;
      if (occ !== OCC_W'($countones(dut.valid_s[DEPTH:1]))) begin
        miscompares++;
        $display("[TB] FAIL occ_popcount t=%0t: occ=%0d, valid flags set=%0d",
                 $time, occ, $countones(dut.valid_s[DEPTH:1]));
      end
    end
  end

  task automatic addVec(input string name, input logic e, input logic dv,
                        input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] eq,
                        input logic eqv, input logic [OCC_W-1:0] eocc);
    vec_t v;
    v.name = name; v.en = e; v.dv = dv; v.d = dd;
    v.expQ = eq; v.expQv = eqv; v.expOcc = eocc;
    tbl.push_back(v);
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, return at
  // the next falling edge so outputs are sampled away from the active edge.
  task automatic applyStimulus(input logic e, input logic dv,
                               input logic [WIDTH-1:0] dd);
    en = e; d_valid = dv; d = dd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] eq,
                             input logic eqv, input logic [OCC_W-1:0] eocc);
    vectors++;
    if (q !== eq || q_valid !== eqv || occ !== eocc) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t: got q=%h q_valid=%b occ=%0d, expected q=%h q_valid=%b occ=%0d",
               name, $time, q, q_valid, occ, eq, eqv, eocc);
    end
  endtask

  initial begin
    // ---- vector table: {name, en, d_valid, d, exp q, exp q_valid, exp occ}
    // First capture after reset: A5 visible after the 4th advancing edge.
    addVec("first_e1",   1, 1, 8'hA5, 8'h00, 0, 1);
    addVec("first_e2",   1, 0, 8'h00, 8'h00, 0, 1);
    addVec("first_e3",   1, 0, 8'h00, 8'h00, 0, 1);
    addVec("first_e4",   1, 0, 8'h00, 8'hA5, 1, 1);
    addVec("first_out",  1, 0, 8'h00, 8'hA5, 0, 0);
    // Streaming 1..6: occ climbs to 4 and holds while words flow through.
    addVec("stream_1",   1, 1, 8'h01, 8'hA5, 0, 1);
    addVec("stream_2",   1, 1, 8'h02, 8'hA5, 0, 2);
    addVec("stream_3",   1, 1, 8'h03, 8'hA5, 0, 3);
    addVec("stream_4",   1, 1, 8'h04, 8'h01, 1, 4);
    addVec("stream_5",   1, 1, 8'h05, 8'h02, 1, 4);
    addVec("stream_6",   1, 1, 8'h06, 8'h03, 1, 4);
    // Bubble: 11 / FF(invalid) / 22. FF must never reach q.
    addVec("bub_11",     1, 1, 8'h11, 8'h04, 1, 4);
    addVec("bub_ff",     1, 0, 8'hFF, 8'h05, 1, 3);
    addVec("bub_22",     1, 1, 8'h22, 8'h06, 1, 3);
    addVec("bub_d1",     1, 0, 8'h00, 8'h11, 1, 2);
    addVec("bub_hole",   1, 0, 8'h00, 8'h11, 0, 1);
    addVec("bub_d3",     1, 0, 8'h00, 8'h22, 1, 1);
    addVec("bub_empty",  1, 0, 8'h00, 8'h22, 0, 0);
    // Stall: two words in, three en=0 edges (d_valid=1 ignored), then drain.
    addVec("stall_in33", 1, 1, 8'h33, 8'h22, 0, 1);
    addVec("stall_in44", 1, 1, 8'h44, 8'h22, 0, 2);
    addVec("stall_h1",   0, 1, 8'hEE, 8'h22, 0, 2);
    addVec("stall_h2",   0, 1, 8'hEE, 8'h22, 0, 2);
    addVec("stall_h3",   0, 1, 8'hEE, 8'h22, 0, 2);
    addVec("stall_r1",   1, 0, 8'h00, 8'h22, 0, 2);
    addVec("stall_r2",   1, 0, 8'h00, 8'h33, 1, 2);
    addVec("stall_r3",   1, 0, 8'h00, 8'h44, 1, 1);
    addVec("stall_r4",   1, 0, 8'h00, 8'h44, 0, 0);

    rst_n = 1'b1; en = 1'b0; d_valid = 1'b0; d = '0;
`ifdef REG_PIPE_SCLR_EN
    sclr = 1'b0;
`endif

    // ---- asynchronous reset mid-cycle, checked before any clock edge
    #10 rst_n = 1'b0;
    #1  checkOutput("reset_async", 8'h00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_hold", 8'h00, 0, 0);
    rst_n = 1'b1;
    invOn = 1'b1;

    // ---- table
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].en, tbl[i].dv, tbl[i].d);
      checkOutput(tbl[i].name, tbl[i].expQ, tbl[i].expQv, tbl[i].expOcc);
    end

    // ---- mid-stream reset with three words in flight
    applyStimulus(1, 1, 8'h51);
    applyStimulus(1, 1, 8'h52);
    applyStimulus(1, 1, 8'h53);
    checkOutput("ms_fill", 8'h44, 0, 3);
    #2 rst_n = 1'b0;
    #1 checkOutput("ms_async", 8'h00, 0, 0);
    en = 1'b1; d_valid = 1'b1; d = 8'h77;
    @(posedge clk);
    #1 checkOutput("ms_in_reset", 8'h00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1, 0, 8'h00);
      checkOutput("ms_no_stale", 8'h00, 0, 0);
    end
    applyStimulus(1, 1, 8'h3C);
    for (int k = 0; k < DEPTH - 1; k++) begin
      applyStimulus(1, 0, 8'h00);
    end
    checkOutput("ms_recapture", 8'h3C, 1, 1);

`ifdef REG_PIPE_SCLR_EN
    // ---- flush a full pipe while a new word is presented
    applyStimulus(1, 1, 8'hA1);
    applyStimulus(1, 1, 8'hA2);
    applyStimulus(1, 1, 8'hA3);
    applyStimulus(1, 1, 8'hA4);
    checkOutput("flush_full", 8'hA1, 1, 4);
    sclr = 1'b1;
    applyStimulus(1, 1, 8'hB0);
    sclr = 1'b0;
    checkOutput("flush_clear", 8'h00, 0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1, 0, 8'h00);
      checkOutput("flush_dropped", 8'h00, 0, 0);
    end
`endif

    invOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
